// File: rtl/demux_pkg.sv
// Shared types for the 2-way word demultiplexer.
package demux_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    DEST0 = 1'b0,
    DEST1 = 1'b1
  } dest_e;

endpackage

// File: rtl/demux_fifo.sv
// Synchronous word FIFO; a push shows on head/valid one cycle later, no bypass.
// Pushes while full and pops while empty are ignored; the caller gates push on ~full.
module demux_fifo
  import demux_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  word_t push_data,
  output logic  full,
  input  logic  pop,
  output word_t head,
  output logic  valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  word_t         mem [DEPTH];

  logic do_push;
  logic do_pop;

  // Extra pointer MSB distinguishes full from empty when addresses match.
  assign valid = (wptr != rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign head  = mem[rptr[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/demux32_2way.sv
// Registered 1-to-2 word demux: each word lands in FIFO[in_sel], visible one cycle later.
// in_ready drops only when the selected FIFO is full, so a stalled sink never blocks the other.
module demux32_2way
  import demux_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [WORD_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [WORD_W-1:0] out1_data,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  dest_e sel;
  logic  full0;
  logic  full1;
  logic  accept;
  logic  push0;
  logic  push1;

  assign sel = dest_e'(in_sel);

  // Full flags are registered state, so no pass-through into a FIFO being popped.
  assign in_ready = (sel == DEST1) ? ~full1 : ~full0;
  assign accept   = in_valid && in_ready;
  assign push0    = accept && (sel == DEST0);
  assign push1    = accept && (sel == DEST1);

  demux_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (in_data),
    .full      (full0),
    .pop       (out0_ready),
    .head      (out0_data),
    .valid     (out0_valid)
  );

  demux_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (in_data),
    .full      (full1),
    .pop       (out1_ready),
    .head      (out1_data),
    .valid     (out1_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (push0) cnt0 <= cnt0 + CNT_W'(1);
      if (push1) cnt1 <= cnt1 + CNT_W'(1);
    end
  end

endmodule
